// File: rtl/riu_access_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | riu_access_arbiter                                                     |
// | Round-robin sharing of the RIU bus between NUM_REQ requesters.         |
// | Optional macro RIU_TIMEOUT_EN bounds the read wait with an error.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module riu_access_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_wr,
  input  logic [6*NUM_REQ-1:0]    req_addr,
  input  logic [16*NUM_REQ-1:0]   req_wr_data,
  input  logic [2*NUM_REQ-1:0]    req_nibble,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [15:0]             rsp_rd_data,
  output logic                    rsp_err,
  output logic [5:0]              riu_addr,
  output logic [15:0]             riu_wr_data,
  output logic                    riu_wr_en,
  output logic [1:0]              riu_nibble_sel,
  input  logic [15:0]             riu_rddata_0,
  input  logic [15:0]             riu_rddata_1,
  input  logic [15:0]             riu_rddata_2,
  input  logic [15:0]             riu_rddata_3,
  input  logic                    riu_valid_0,
  input  logic                    riu_valid_1,
  input  logic                    riu_valid_2,
  input  logic                    riu_valid_3,
  input  logic                    riu_prsnt_0,
  input  logic                    riu_prsnt_1,
  input  logic                    riu_prsnt_2,
  input  logic                    riu_prsnt_3,
  output logic                    busy
);
  localparam int c_IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  generate
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_W)) begin : g_to_w_check
      $error("TO_W cannot hold TIMEOUT_CYCLES");
    end
  endgenerate

  state_t               r_state, w_state_nxt;
  logic [c_IDX_W-1:0]   r_last_grant, w_last_grant_nxt, r_g, w_idx;
  logic                 w_found, w_latch;
  logic                 r_wr, r_err, w_err_nxt;
  logic [5:0]           r_addr;
  logic [15:0]          r_wr_data, r_rd_data, w_rd_data_nxt;
  logic [1:0]           r_nibble;
  logic                 w_prsnt_sel, w_valid_sel;
  logic [15:0]          w_rddata_sel;
  logic [NUM_REQ-1:0]   w_req_ready_nxt, w_rsp_valid_nxt;
  logic [15:0]          w_rsp_rd_data_nxt, w_riu_wr_data_nxt;
  logic                 w_rsp_err_nxt, w_riu_wr_en_nxt;
  logic [5:0]           w_riu_addr_nxt;
  logic [1:0]           w_riu_nibble_sel_nxt;
`ifdef RIU_TIMEOUT_EN
  logic [TO_W-1:0]      r_to_cnt, w_to_cnt_nxt;
`endif

  // Scan upward from the requester after the last grant, wrapping around.
  always_comb begin : arb
    int cand;
    w_found = 1'b0;
    w_idx   = '0;
    cand    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(r_last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!w_found && req_valid[c_IDX_W'(cand)]) begin
        w_found = 1'b1;
        w_idx   = c_IDX_W'(cand);
      end
    end
  end

  always_comb begin
    w_prsnt_sel  = riu_prsnt_0;
    w_valid_sel  = riu_valid_0;
    w_rddata_sel = riu_rddata_0;
    case (r_nibble)
      2'd1:    begin w_prsnt_sel = riu_prsnt_1; w_valid_sel = riu_valid_1; w_rddata_sel = riu_rddata_1; end
      2'd2:    begin w_prsnt_sel = riu_prsnt_2; w_valid_sel = riu_valid_2; w_rddata_sel = riu_rddata_2; end
      2'd3:    begin w_prsnt_sel = riu_prsnt_3; w_valid_sel = riu_valid_3; w_rddata_sel = riu_rddata_3; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_latch              = 1'b0;
    w_last_grant_nxt     = r_last_grant;
    w_err_nxt            = r_err;
    w_rd_data_nxt        = r_rd_data;
    w_req_ready_nxt      = '0;
    w_rsp_valid_nxt      = '0;
    w_rsp_rd_data_nxt    = '0;
    w_rsp_err_nxt        = 1'b0;
    w_riu_addr_nxt       = '0;
    w_riu_wr_data_nxt    = '0;
    w_riu_wr_en_nxt      = 1'b0;
    w_riu_nibble_sel_nxt = '0;
`ifdef RIU_TIMEOUT_EN
    w_to_cnt_nxt         = r_to_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_latch                = 1'b1;
          w_req_ready_nxt[w_idx] = 1'b1;
          w_state_nxt            = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_riu_addr_nxt       = r_addr;
        w_riu_wr_data_nxt    = r_wr_data;
        w_riu_nibble_sel_nxt = r_nibble;
        w_rd_data_nxt        = '0;
        if (!w_prsnt_sel) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (r_wr) begin
          w_riu_wr_en_nxt = 1'b1;
          w_err_nxt       = 1'b0;
          w_state_nxt     = ST_RESP;
        end else begin
          w_err_nxt   = 1'b0;
`ifdef RIU_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
          w_state_nxt = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        w_riu_addr_nxt       = r_addr;
        w_riu_wr_data_nxt    = r_wr_data;
        w_riu_nibble_sel_nxt = r_nibble;
        if (w_valid_sel) begin
          w_rd_data_nxt = w_rddata_sel;
          w_err_nxt     = 1'b0;
          w_state_nxt   = ST_RESP;
        end
`ifdef RIU_TIMEOUT_EN
        else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          w_rd_data_nxt = '0;
          w_err_nxt     = 1'b1;
          w_state_nxt   = ST_RESP;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        w_rsp_valid_nxt[r_g] = 1'b1;
        w_rsp_rd_data_nxt    = r_rd_data;
        w_rsp_err_nxt        = r_err;
        w_last_grant_nxt     = r_g;
        w_state_nxt          = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_grant   <= c_IDX_W'(NUM_REQ - 1);
      r_g            <= '0;
      r_wr           <= 1'b0;
      r_addr         <= '0;
      r_wr_data      <= '0;
      r_nibble       <= '0;
      r_rd_data      <= '0;
      r_err          <= 1'b0;
      req_ready      <= '0;
      rsp_valid      <= '0;
      rsp_rd_data    <= '0;
      rsp_err        <= 1'b0;
      riu_addr       <= '0;
      riu_wr_data    <= '0;
      riu_wr_en      <= 1'b0;
      riu_nibble_sel <= '0;
      busy           <= 1'b0;
`ifdef RIU_TIMEOUT_EN
      r_to_cnt       <= '0;
`endif
    end else begin
      if (w_latch) begin
        r_g       <= w_idx;
        r_wr      <= req_wr[w_idx];
        r_addr    <= req_addr[6*w_idx +: 6];
        r_wr_data <= req_wr_data[16*w_idx +: 16];
        r_nibble  <= req_nibble[2*w_idx +: 2];
      end
      r_last_grant   <= w_last_grant_nxt;
      r_rd_data      <= w_rd_data_nxt;
      r_err          <= w_err_nxt;
      req_ready      <= w_req_ready_nxt;
      rsp_valid      <= w_rsp_valid_nxt;
      rsp_rd_data    <= w_rsp_rd_data_nxt;
      rsp_err        <= w_rsp_err_nxt;
      riu_addr       <= w_riu_addr_nxt;
      riu_wr_data    <= w_riu_wr_data_nxt;
      riu_wr_en      <= w_riu_wr_en_nxt;
      riu_nibble_sel <= w_riu_nibble_sel_nxt;
      busy           <= (w_state_nxt != ST_IDLE);
`ifdef RIU_TIMEOUT_EN
      r_to_cnt       <= w_to_cnt_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/riu_access_arbiter.md
Name: riu_access_arbiter

Overview:
- Shares the single RIU write/address bus and the four per-nibble RIU read-back paths between NUM_REQ independent requesters.
- Typical requesters: BTVAL calibration, VTC monitor, host register bridge.
- Sits between those requesters and the shared clock/reset block's RIU ports, in the riu_clk domain.
- Round-robin arbitration, one transaction in flight, read completion on per-nibble riu_valid, absent-nibble detection.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, max WAIT_RD cycles before error completion (used only with RIU_TIMEOUT_EN).
- TO_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  RIU clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_wr  in  NUM_REQ  1=write, 0=read.
- req_addr  in  6*NUM_REQ  flat; requester i at [6i+5:6i].
- req_wr_data  in  16*NUM_REQ  flat write data.
- req_nibble  in  2*NUM_REQ  flat target nibble 0..3.
- req_ready  out  NUM_REQ  one-cycle accept pulse to granted requester.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to owning requester.
- rsp_rd_data  out  16  read data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- riu_addr  out  6  RIU address.
- riu_wr_data  out  16  RIU write data.
- riu_wr_en  out  1  RIU write strobe.
- riu_nibble_sel  out  2  RIU nibble select.
- riu_rddata_0..3  in  16 each  per-nibble read data.
- riu_valid_0..3  in  1 each  per-nibble read valid.
- riu_prsnt_0..3  in  1 each  per-nibble present.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset_n=0 at edge): state=IDLE. All outputs 0. last_grant=NUM_REQ-1, so requester 0 wins first. Timeout counter=0. Reset mid-transaction aborts it with no rsp_valid.
- States: IDLE, ISSUE, WAIT_RD, RESP. All outputs registered.
- IDLE: if any req_valid, pick the first set bit scanning from last_grant+1 upward with wrap.
  - Latch that requester's wr/addr/data/nibble and index g.
  - Pulse req_ready[g] for 1 cycle; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle): drive riu_addr/riu_nibble_sel/riu_wr_data from the latch; riu_wr_en=1 only for writes.
  - riu_prsnt of the selected nibble =0: no strobe (riu_wr_en=0), go to RESP with err=1, rd_data=0.
  - Write: go to RESP with err=0.
  - Read: clear the counter, go to WAIT_RD.
- WAIT_RD: hold riu_addr/riu_nibble_sel; riu_wr_en=0.
  - Sample only the selected nibble's riu_valid; valid from other nibbles is ignored.
  - On valid: capture that nibble's riu_rddata, go to RESP with err=0.
  - riu_valid during the ISSUE cycle is ignored.
- RESP (1 cycle): rsp_valid[g]=1 with rsp_rd_data/rsp_err. Set last_grant=g; go to IDLE.
  - rsp_rd_data=0 for writes.
  - Outside RESP, rsp_rd_data and rsp_err are 0.
- riu_addr/riu_wr_data/riu_nibble_sel are 0 in IDLE and RESP.
- Latency from accept to completion:
  - write: 3 cycles (IDLE, ISSUE, RESP);
  - absent nibble: 3 cycles;
  - read: 3 + number of WAIT_RD cycles.
- Requesters hold req_* stable until req_ready. They drop req_valid in the cycle after req_ready, or the request is re-arbitrated as new.
- Requester i holding req_valid continuously is granted at most once per NUM_REQ grants while others request.
- Requests arriving while busy wait; nothing is dropped.

Optional Feature:
- Macro: RIU_TIMEOUT_EN.
- Defined: the counter increments each WAIT_RD cycle. When count==TIMEOUT_CYCLES-1 without valid, go to RESP with err=1, rd_data=0. Valid in that same cycle takes priority (err=0).
- Undefined: no counter. WAIT_RD waits indefinitely; only reset_n exits.

Test Plan:
- Reset release with req_valid=0 -> all outputs 0, busy=0, stays idle 10 cycles.
- Req 0 write, addr 0x12, data 0xA5A5, nibble 2, prsnt_2=1 -> riu_wr_en=1 one cycle with riu_addr=0x12, riu_wr_data=0xA5A5, riu_nibble_sel=2. rsp_valid[0] 2 cycles after req_ready[0]; rsp_err=0.
- Req 1 read nibble 3; riu_valid_3 asserted 4 cycles after ISSUE with rddata_3=0x1C3; riu_valid_0 pulsed meanwhile -> the riu_valid_0 pulse is ignored; rsp_valid[1] with rsp_rd_data=0x1C3, rsp_err=0.
- All 4 requesters hold req_valid from reset -> grant order 0,1,2,3,0; each rsp_valid matches its grant.
- Read to nibble 1 with riu_prsnt_1=0 -> riu_wr_en never asserted; rsp_valid 3 cycles after accept; rsp_err=1, rsp_rd_data=0.
- RIU_TIMEOUT_EN, TIMEOUT_CYCLES=8, read with no valid -> rsp_err=1 after 8 WAIT_RD cycles. Repeat without macro -> busy stays 1 for 100 cycles; reset_n=0 returns to IDLE with no rsp_valid.
